pass_entry: RTL and testbench
=============================

// Module: pass_entry
// PURPOSE
//   Password capture stage upstream of the 7-segment display driver and the 16-bit AES core.
//   Debounces ENTER/CLEAR buttons and collects four 4-bit switch nibbles into a 16-bit word.
//   Drives four 5-bit character codes to the display mux.
//   Offers the completed word downstream over a valid/ready handshake.
// PARAMETERS
//   DEB_CYCLES  1_000_000  cycles a synchronized button must differ from its debounced level before it flips (10 ms @ 100 MHz); >=2
//   BLANK_CODE  5'd31      character code for an unfilled digit slot
//   MASK_CODE   5'd30      character code for a filled slot when masking is compiled in
// PORTS
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   sw          in   4   nibble to enter (quasi-static switches, no sync)
//   btn_enter   in   1   raw ENTER button, asynchronous
//   btn_clear   in   1   raw CLEAR button, asynchronous
//   pass_ready  in   1   downstream accepts pass_word
//   pass_valid  out  1   pass_word complete and offered
//   pass_word   out  16  entered password; first nibble in [15:12], last in [3:0]
//   disp0       out  5   rightmost digit code (most recent nibble)
//   disp1       out  5   second digit code from the right
//   disp2       out  5   third digit code from the right
//   disp3       out  5   leftmost digit code (oldest nibble)
//   digit_cnt   out  3   nibbles entered, 0..4
// BEHAVIOUR
//   Single clock domain: clk. Reset is synchronous and active-high on reset.
//   Reset: all state returns to reset on the next clk edge, including mid-entry and mid-handshake.
//     pass_valid=0, pass_word=0, digit_cnt=0, disp0..3=BLANK_CODE, state=COLLECT, debouncers cleared.
//   Debouncer, one per button:
//     2-FF synchronizer s1 -> s2.
//     Counter: if s2==deb then cnt<=0;
//       else if cnt==DEB_CYCLES-1 then deb<=s2 and cnt<=0;
//       else cnt<=cnt+1.
//     press = deb & ~deb_d, a single-cycle pulse on the debounced rising edge only.
//     Bounce shorter than DEB_CYCLES is rejected. Release produces no pulse.
//     Button held high through sample edge 1 gives press high in the cycle before edge DEB_CYCLES+3.
//     The FSM acts on press at edge DEB_CYCLES+3.
//   FSM states:
//     COLLECT, digit_cnt<4:
//       enter press: pass_word <= {pass_word[11:0], sw}, digit_cnt++.
//       When digit_cnt becomes 4, go to OFFER.
//     OFFER: pass_valid=1, pass_word held stable. Enter presses ignored.
//       Edge with pass_valid & pass_ready: transfer; go to HOLD; pass_valid=0 from next cycle.
//       pass_ready may be high before valid; the transfer then occurs on the first OFFER edge.
//     HOLD: word and displays retained, pass_valid=0, enter ignored.
//     Clear press in any state: go to COLLECT, pass_word=0, digit_cnt=0, pass_valid=0 next cycle.
//       This aborts an un-accepted offer.
//     Clear and enter press in the same cycle: clear wins, nibble discarded.
//   Display outputs are combinational from the registers, so they change on the same edge as pass_word.
//     Slot k (k=0..3) is filled iff k < digit_cnt.
//     Filled slot: disp_k = {1'b0, pass_word[4k+3:4k]}. Unfilled slot: BLANK_CODE.
//   Widths: digit_cnt saturates at 4 and never wraps. Debounce counter is $clog2(DEB_CYCLES) bits.
// CONFIGURATION
//   PASS_MASK_EN defined: every filled slot shows MASK_CODE instead of its nibble.
//     pass_word and the handshake are unchanged.
//   PASS_MASK_EN undefined: filled slots show the nibble value as above.
// TESTING (bench sets DEB_CYCLES=4)
//   1 Reset mid-entry after 2 nibbles:
//     -> next edge digit_cnt=0, pass_word=0, all disp=31, pass_valid=0.
//   2 Enter sw=A,5,5,C with pass_ready=0:
//     -> pass_word=16'hA55C, pass_valid=1, disp3..0 = 10,5,5,12, digit_cnt=4.
//     Further enter presses leave the word unchanged.
//   3 From scenario 2, pulse pass_ready for 1 cycle:
//     -> transfer on that edge, pass_valid=0 next cycle, displays still 10,5,5,12.
//   4 btn_enter bounces high 3 cycles / low 1 cycle, then holds high:
//     -> exactly one nibble captured, at edge DEB_CYCLES+3 after the final rise.
//   5 Enter and clear pressed together with digit_cnt=3:
//     -> digit_cnt=0, pass_word=0, no capture. Clear during OFFER -> pass_valid drops next cycle.
//   6 PASS_MASK_EN build, enter 3,7:
//     -> disp1=disp0=30, disp3=disp2=31, pass_word=16'h0037.

Source files
------------

// File: rtl/pass_entry.sv
// Password entry: debounced ENTER/CLEAR collect four switch nibbles and offer them on valid/ready.
// Build option PASS_MASK_EN shows MASK_CODE on filled display slots instead of the nibble.

module pass_entry_deb #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q, deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= btn_i;
      s2_q       <= s1_q;
      deb_prev_q <= deb_q;
      // The counter restarts whenever the synchronized level agrees again, rejecting short bounces.
      if (s2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = deb_q & ~deb_prev_q;
endmodule

module pass_entry #(
  parameter int         DEB_CYCLES = 1_000_000,
  parameter logic [4:0] BLANK_CODE = 5'd31,
  parameter logic [4:0] MASK_CODE  = 5'd30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic        pass_ready,
  output logic        pass_valid,
  output logic [15:0] pass_word,
  output logic [4:0]  disp0,
  output logic [4:0]  disp1,
  output logic [4:0]  disp2,
  output logic [4:0]  disp3,
  output logic [2:0]  digit_cnt
);
  typedef enum logic [1:0] {COLLECT, OFFER, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        enter_press, clear_press;
  logic [4:0]  slot [4];

  pass_entry_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk(clk), .reset(reset), .btn_i(btn_enter), .press_o(enter_press)
  );
  pass_entry_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk(clk), .reset(reset), .btn_i(btn_clear), .press_o(clear_press)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    // Clear outranks everything, including a simultaneous enter and a pending offer.
    if (clear_press) begin
      state_d = COLLECT;
      word_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (enter_press && cnt_q < 3'd4) begin
            word_d = {word_q[11:0], sw};
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd3) state_d = OFFER;
          end
        end
        OFFER:   if (pass_ready) state_d = HOLD;
        HOLD:    state_d = HOLD;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot[k] = BLANK_CODE;
      if (3'(k) < cnt_q) begin
`ifdef PASS_MASK_EN
        slot[k] = MASK_CODE;
`else
        slot[k] = {1'b0, word_q[4*k +: 4]};
`endif
      end
    end
  end

  assign pass_valid = (state_q == OFFER);
  assign pass_word  = word_q;
  assign digit_cnt  = cnt_q;
  assign disp0      = slot[0];
  assign disp1      = slot[1];
  assign disp2      = slot[2];
  assign disp3      = slot[3];

`ifndef PASS_MASK_EN
  // Keeps MASK_CODE referenced in the unmasked build.
  logic unused_mask;
  assign unused_mask = ^MASK_CODE;
`endif
endmodule

// File: tb/tb_pass_entry.sv
// Bench for pass_entry with a short debounce; offered words are queued at entry and matched at transfer.
module tb_pass_entry;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sw = 4'd0;
  logic        btn_enter = 1'b0;
  logic        btn_clear = 1'b0;
  logic        pass_ready = 1'b0;
  logic        pass_valid;
  logic [15:0] pass_word;
  logic [4:0]  disp0, disp1, disp2, disp3;
  logic [2:0]  digit_cnt;

  int          n_err = 0;
  int          n_chk = 0;
  int          n_xfer = 0;
  logic [15:0] exp_q [$];
  logic [15:0] m_word = 16'd0;
  int          m_cnt = 0;

  pass_entry #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .pass_ready(pass_ready), .pass_valid(pass_valid), .pass_word(pass_word),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_disp(input int k);
    if (k >= m_cnt) return 5'd31;
`ifdef PASS_MASK_EN
    return 5'd30;
`else
    return {1'b0, m_word[4*k +: 4]};
`endif
  endfunction

  // Inputs change 2 time units after a rising edge; checks happen at the same point.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_cnt"},   32'(digit_cnt),  32'(m_cnt));
    chk({tag, "_word"},  32'(pass_word),  32'(m_word));
    chk({tag, "_valid"}, 32'(pass_valid), 32'(exp_q.size() != 0));
    chk({tag, "_d0"},    32'(disp0),      32'(exp_disp(0)));
    chk({tag, "_d1"},    32'(disp1),      32'(exp_disp(1)));
    chk({tag, "_d2"},    32'(disp2),      32'(exp_disp(2)));
    chk({tag, "_d3"},    32'(disp3),      32'(exp_disp(3)));
  endtask

  // Holds the buttons from a fresh rise; the FSM should act exactly at edge DEB+3.
  task automatic press(input logic en, input logic cl, input logic [3:0] nib, input logic bounce);
    sw = nib;
    if (bounce) begin
      btn_enter = 1'b1;
      cyc(3);
      btn_enter = 1'b0;
      cyc(1);
    end
    btn_enter = en;
    btn_clear = cl;
    cyc(DEB + 2);
    check_all("pre");
    cyc(1);
    if (cl) begin
      m_word = 16'd0;
      m_cnt  = 0;
      exp_q.delete();
    end else if (en && m_cnt < 4) begin
      m_word = {m_word[11:0], nib};
      m_cnt++;
      if (m_cnt == 4) exp_q.push_back(m_word);
    end
    check_all("post");
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    cyc(DEB + 4);
    check_all("rel");
  endtask

  // Transfer happens on the edge following a sample with valid and ready both high.
  always @(negedge clk) begin
    if (!reset && pass_valid && pass_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL xfer_unexpected: got word %0h expected no transfer", pass_word);
      end else begin
        chk("xfer_word", 32'(pass_word), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    check_all("reset");
    reset = 1'b0;
    cyc(1);

    // Reset mid-entry
    press(1'b1, 1'b0, 4'h3, 1'b0);
    press(1'b1, 1'b0, 4'h9, 1'b0);
    chk("s1_cnt2", 32'(digit_cnt), 32'd2);
    reset = 1'b1;
    cyc(1);
    m_word = 16'd0;
    m_cnt  = 0;
    check_all("s1_rst");
    reset = 1'b0;
    cyc(1);

    // Full word, ready low, then a surplus enter
    press(1'b1, 1'b0, 4'hA, 1'b0);
    press(1'b1, 1'b0, 4'h5, 1'b0);
    press(1'b1, 1'b0, 4'h5, 1'b0);
    press(1'b1, 1'b0, 4'hC, 1'b0);
    chk("s2_word", 32'(pass_word), 32'h0000A55C);
    chk("s2_valid", 32'(pass_valid), 32'd1);
`ifndef PASS_MASK_EN
    chk("s2_d3", 32'(disp3), 32'd10);
    chk("s2_d0", 32'(disp0), 32'd12);
`endif
    press(1'b1, 1'b0, 4'hF, 1'b0);
    chk("s2_hold_word", 32'(pass_word), 32'h0000A55C);

    // One-cycle ready pulse
    pass_ready = 1'b1;
    cyc(1);
    pass_ready = 1'b0;
    check_all("s3");
    chk("s3_xfers", 32'(n_xfer), 32'd1);
    cyc(2);
    chk("s3_valid_low", 32'(pass_valid), 32'd0);

    // Bouncy enter after a clear
    press(1'b0, 1'b1, 4'h0, 1'b0);
    press(1'b1, 1'b0, 4'h6, 1'b1);
    chk("s4_word", 32'(pass_word), 32'h00000006);

    // Enter and clear together at three digits
    press(1'b1, 1'b0, 4'h1, 1'b0);
    press(1'b1, 1'b0, 4'h2, 1'b0);
    chk("s5_cnt3", 32'(digit_cnt), 32'd3);
    press(1'b1, 1'b1, 4'h7, 1'b0);
    chk("s5_cnt0", 32'(digit_cnt), 32'd0);

    // Clear aborts an un-accepted offer
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 4'(i + 8), 1'b0);
    chk("s5_offer", 32'(pass_valid), 32'd1);
    press(1'b0, 1'b1, 4'h0, 1'b0);
    chk("s5_abort", 32'(pass_valid), 32'd0);

    // Ready already high before the offer appears
    pass_ready = 1'b1;
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 4'(i + 1), 1'b0);
    pass_ready = 1'b0;
    chk("early_xfers", 32'(n_xfer), 32'd2);

    // Two-digit entry for the display slots
    press(1'b0, 1'b1, 4'h0, 1'b0);
    press(1'b1, 1'b0, 4'h3, 1'b0);
    press(1'b1, 1'b0, 4'h7, 1'b0);
    chk("s6_word", 32'(pass_word), 32'h00000037);
    chk("s6_d3", 32'(disp3), 32'd31);
`ifdef PASS_MASK_EN
    chk("s6_d0", 32'(disp0), 32'd30);
`else
    chk("s6_d0", 32'(disp0), 32'd7);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
